// File: rtl/restoring_divider_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, WIDTH iterations.
// Latency: start accepted at edge k -> done pulses in the cycle after edge k+WIDTH.
// No backpressure: start is honoured only in IDLE, ignored (not queued) while RUN/DONE.
module restoring_divider_seq #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Remainder path is one bit wider than the operands so the borrow is explicit.
    localparam int RW = WIDTH + 1;
    // Trial subtract is split into a low block and a carry-selected high block.
    localparam int LW = RW / 2;
    localparam int HW = RW - LW;

    // Counter value on the final iteration.
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quot;
    logic [RW-1:0]    rem;
    logic [CW-1:0]    cnt;

    // Per-iteration datapath signals
    logic [RW-1:0]    rem_sh;
    logic [RW-1:0]    sub_op;
    logic [LW:0]      lo_diff;
    logic             lo_borrow;
    logic [HW-1:0]    hi_no_borrow;
    logic [HW-1:0]    hi_borrow;
    logic [RW-1:0]    diff;
    logic             q_bit;
    logic [RW-1:0]    rem_nxt;
    logic [WIDTH-1:0] quot_nxt;
    logic             accept;
    logic             last_iter;

    assign accept    = (state == S_IDLE) && start;
    assign last_iter = (state == S_RUN) && (cnt == LAST);

    // One restoring step: shift in the next dividend bit, trial-subtract the
    // divisor, and keep the difference only when it did not go negative.
    always_comb begin
        rem_sh       = {rem[WIDTH-1:0], dividend[WIDTH-1]};
        sub_op       = {1'b0, divisor};

        // Low block resolves its own borrow-out.
        lo_diff      = {1'b0, rem_sh[LW-1:0]} - {1'b0, sub_op[LW-1:0]};
        lo_borrow    = lo_diff[LW];

        // High block is computed for both borrow-in cases in parallel and the
        // low block's borrow picks one, keeping the borrow chain short.
        hi_no_borrow = rem_sh[RW-1:LW] - sub_op[RW-1:LW];
        hi_borrow    = rem_sh[RW-1:LW] - sub_op[RW-1:LW] - HW'(1);

        diff         = {(lo_borrow ? hi_borrow : hi_no_borrow), lo_diff[LW-1:0]};

        // rem_sh < 2*divisor always holds, so the wide MSB is a true sign bit.
        q_bit        = ~diff[RW-1];
        rem_nxt      = q_bit ? diff : rem_sh;
        quot_nxt     = {quot[WIDTH-2:0], q_bit};
    end

    // Control FSM: IDLE -> RUN on accepted start, RUN -> DONE after WIDTH steps,
    // DONE -> IDLE unconditionally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state <= S_RUN;
                S_RUN:   if (cnt == LAST) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Iteration registers: loaded on accept, stepped once per clock in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dividend <= '0;
            divisor  <= '0;
            quot     <= '0;
            rem      <= '0;
            cnt      <= '0;
        end else if (accept) begin
            dividend <= a;
            divisor  <= b;
            quot     <= '0;
            rem      <= '0;
            cnt      <= '0;
        end else if (state == S_RUN) begin
            dividend <= {dividend[WIDTH-2:0], 1'b0};
            quot     <= quot_nxt;
            rem      <= rem_nxt;
            cnt      <= cnt + CW'(1);
        end
    end

    // Result registers: updated only on the final iteration so they hold the
    // previous result while a new division is running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
            r <= '0;
        end else if (last_iter) begin
            q <= quot_nxt;
            r <= rem_nxt[WIDTH-1:0];
        end
    end

    // Divide-by-zero flag reflects the operation most recently accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbz <= 1'b0;
        end else if (accept) begin
            dbz <= (b == '0);
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_restoring_divider_seq.sv
// Self-checking bench for restoring_divider_seq (WIDTH=8): scoreboard of expected
// results pushed at start, popped when done pulses.
module tb_restoring_divider_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       busy;
    logic       done;
    logic       dbz;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    restoring_divider_seq #(.WIDTH(8), .CW(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one start pulse at a negedge and push the model's expectation.
    // Returns in the first cycle after the accepting edge; operands are then
    // scrambled to show they are not re-sampled.
    task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v);
        exp_t e;
        if (tb_v == 8'd0) begin
            e.q = 8'hFF; e.r = ta; e.dbz = 1'b1;
        end else begin
            e.q = ta / tb_v; e.r = ta % tb_v; e.dbz = 1'b0;
        end
        sb.push_back(e);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
    endtask

    // Wait (bounded) for done; cyc counts cycles since the accepting edge
    // assuming the call is made in cycle 1.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        #1;
        n_vec++;
        if ({q, r, busy, done, dbz} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0", q, r, busy, done, dbz);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        exp_t e;
        issue(8'd200, 8'd7);
        for (int i = 1; i <= 8; i++) begin
            n_vec++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL basic_busy cycle %0d: got busy=%b done=%b, want busy=1 done=0", i, busy, done);
            end
            @(negedge clk);
        end
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done_cycle9: got done=%b busy=%b, want done=1 busy=0", done, busy);
        end
        e = sb.pop_front();
        n_vec++;
        if ({q, r, dbz} !== {e.q, e.r, e.dbz}) begin
            n_err++;
            $display("FAIL basic_result: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=%b", q, r, dbz, e.q, e.r, e.dbz);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done_pulse: got done=%b after done cycle, want 0", done);
        end
    endtask

    task automatic test_patterns;
        logic [7:0] ta [4] = '{8'd5, 8'd255, 8'd144, 8'd9};
        logic [7:0] tbv[4] = '{8'd9, 8'd1,   8'd12,  8'd9};
        exp_t e;
        int   cyc;
        for (int i = 0; i < 4; i++) begin
            issue(ta[i], tbv[i]);
            wait_done(cyc);
            n_vec++;
            if (cyc != 9) begin
                n_err++;
                $display("FAIL pattern_latency %0d/%0d: got %0d cycles, want 9", ta[i], tbv[i], cyc);
            end
            e = sb.pop_front();
            n_vec++;
            if ({q, r, dbz} !== {e.q, e.r, e.dbz}) begin
                n_err++;
                $display("FAIL pattern_result %0d/%0d: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=%b",
                         ta[i], tbv[i], q, r, dbz, e.q, e.r, e.dbz);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_dbz;
        exp_t e;
        int   cyc;
        issue(8'd77, 8'd0);
        n_vec++;
        if (dbz !== 1'b1) begin
            n_err++;
            $display("FAIL dbz_set_at_start: got dbz=%b, want 1", dbz);
        end
        wait_done(cyc);
        n_vec++;
        if (cyc != 9) begin
            n_err++;
            $display("FAIL dbz_latency: got %0d cycles, want 9", cyc);
        end
        e = sb.pop_front();
        n_vec++;
        if ({q, r, dbz} !== {e.q, e.r, e.dbz}) begin
            n_err++;
            $display("FAIL dbz_result: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=%b", q, r, dbz, e.q, e.r, e.dbz);
        end
        @(negedge clk);
        n_vec++;
        if (dbz !== 1'b1) begin
            n_err++;
            $display("FAIL dbz_hold_idle: got dbz=%b, want 1", dbz);
        end
        issue(8'd10, 8'd3);
        n_vec++;
        if (dbz !== 1'b0 || q !== 8'd255 || r !== 8'd77) begin
            n_err++;
            $display("FAIL dbz_clear_and_hold: got dbz=%b q=%0d r=%0d, want dbz=0 q=255 r=77", dbz, q, r);
        end
        wait_done(cyc);
        e = sb.pop_front();
        n_vec++;
        if ({q, r, dbz} !== {e.q, e.r, e.dbz}) begin
            n_err++;
            $display("FAIL dbz_next_result: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=%b", q, r, dbz, e.q, e.r, e.dbz);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        exp_t e;
        int   cyc;
        issue(8'd200, 8'd7);
        @(negedge clk); @(negedge clk);
        a = 8'd9; b = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        e = sb.pop_front();
        n_vec++;
        if (done !== 1'b1 || {q, r, dbz} !== {e.q, e.r, e.dbz}) begin
            n_err++;
            $display("FAIL ignore_run_start: got done=%b q=%0d r=%0d dbz=%b, want done=1 q=%0d r=%0d dbz=%b",
                     done, q, r, dbz, e.q, e.r, e.dbz);
        end
        a = 8'd9; b = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_done_start: got busy=%b done=%b, want 0 0", busy, done);
        end
        issue(8'd9, 8'd3);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL accept_after_done: got busy=%b, want 1", busy);
        end
        wait_done(cyc);
        e = sb.pop_front();
        n_vec++;
        if (cyc != 9 || {q, r, dbz} !== {e.q, e.r, e.dbz}) begin
            n_err++;
            $display("FAIL accept_after_done_result: got cyc=%0d q=%0d r=%0d, want cyc=9 q=%0d r=%0d", cyc, q, r, e.q, e.r);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        exp_t e;
        int   cyc;
        int   seen;
        issue(8'd200, 8'd7);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({q, r, busy, done, dbz} !== 19'd0) begin
            n_err++;
            $display("FAIL async_reset_outputs: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0", q, r, busy, done, dbz);
        end
        sb.delete();
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
            if (i == 2) rst = 1'b0;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL async_reset_no_done: got %0d done pulses, want 0", seen);
        end
        issue(8'd100, 8'd9);
        wait_done(cyc);
        e = sb.pop_front();
        n_vec++;
        if (cyc != 9 || {q, r, dbz} !== {e.q, e.r, e.dbz}) begin
            n_err++;
            $display("FAIL after_reset_result: got cyc=%0d q=%0d r=%0d dbz=%b, want cyc=9 q=%0d r=%0d dbz=%b",
                     cyc, q, r, dbz, e.q, e.r, e.dbz);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        exp_t e;
        int   cyc;
        logic [7:0] ta, tbv;
        for (int i = 0; i < 1000; i++) begin
            ta  = 8'($urandom);
            tbv = 8'($urandom_range(1, 255));
            issue(ta, tbv);
            wait_done(cyc);
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL random_scoreboard_empty at op %0d", i);
                return;
            end
            e = sb.pop_front();
            n_vec++;
            if (cyc != 9 || {q, r, dbz} !== {e.q, e.r, e.dbz}) begin
                n_err++;
                $display("FAIL random %0d/%0d: got cyc=%0d q=%0d r=%0d dbz=%b, want cyc=9 q=%0d r=%0d dbz=0",
                         ta, tbv, cyc, q, r, dbz, e.q, e.r);
            end
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0) begin
                n_err++;
                $display("FAIL random_double_done %0d/%0d: got done=%b, want 0", ta, tbv, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_dbz();
        test_ignore_start();
        test_async_reset();
        test_random();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/restoring_divider_seq.md
Name: restoring_divider_seq

Overview:
- Multi-cycle unsigned integer divider; the inverse operation to the team's carry-select adder blocks.
- Produces quotient and remainder by restoring division, one quotient bit per clock.
- Each iteration does a trial subtract, using a carry-select style borrow/no-borrow choice.
- Sits beside the adder library as the arithmetic unit for datapaths that need a/b and a%b without a combinational array.

Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits (>=2).
- CW, 4, counter width; must satisfy 2**CW > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  dividend; captured on accepted start
- b  input  WIDTH  divisor; captured on accepted start
- q  output  WIDTH  quotient
- r  output  WIDTH  remainder
- busy  output  1  high while iterating (RUN)
- done  output  1  one-cycle pulse; q/r/dbz valid
- dbz  output  1  divide-by-zero flag for the last operation

Behaviour:
- Reset (async, rst=1): state=IDLE, q=0, r=0, busy=0, done=0, dbz=0, internal registers and counter = 0.
  - Takes effect immediately, mid-operation included.
  - The in-flight result is discarded; no done pulse.
- States:
  - IDLE: start=1 at edge k captures a→dividend shift reg, b→divisor reg. Also sets rem(WIDTH+1 bits)=0, cnt=0, dbz=(b==0). Next state RUN.
  - RUN: busy=1. Each edge performs one iteration and increments cnt.
    - Iteration: rem' = {rem[WIDTH-1:0], dividend MSB}; shift dividend left 1.
    - Compute diff = rem' - {0,divisor} in WIDTH+1 bits.
    - If no borrow (diff MSB=0): rem=diff, shift 1 into quotient LSB.
    - Else: rem=rem', shift 0 into quotient LSB.
    - After WIDTH iterations (edge k+WIDTH), go to DONE. q and r load from the quotient reg and rem[WIDTH-1:0] at that same edge.
  - DONE: done=1 for exactly this one cycle, busy=0. Next edge → IDLE unconditionally.
- Latency: start accepted at edge k → done high in the cycle following edge k+WIDTH. The next start can be accepted at edge k+WIDTH+2 at the earliest.
- start is ignored in RUN and DONE. It is not queued, and a, b are not re-sampled.
- q, r and dbz hold their last values until the next completion; they are not cleared on a new start.
- Divide by zero: the algorithm runs normally, with the same latency.
  - Every trial subtract succeeds, so q = all ones (2**WIDTH-1) and r = a.
  - dbz=1 is asserted from the edge that accepts start. It holds until the next accepted start with b≠0.
- a < b: q=0, r=a. a = b: q=1, r=0.
- Width rule: the remainder path is WIDTH+1 bits so the borrow is explicit. The output r is always < b when b≠0.
- Invariant at done (b≠0): a == q*b + r.
- a and b may change freely after the accepting edge without affecting the result.

Test Plan:
- WIDTH=8, rst pulse, then start with a=200, b=7 → busy for 8 cycles; done in the 9th cycle after the start edge with q=28, r=4, dbz=0; done low the cycle after.
- a=5, b=9 → q=0, r=5. Then a=255, b=1 → q=255, r=0. Then a=144, b=12 → q=12, r=0.
- a=77, b=0 → done after the same 8+1 latency; q=255, r=77, dbz=1. A following a=10, b=3 → dbz clears at its start edge; q=3, r=1.
- Start a=200, b=7. Pulse start with a=9, b=3 during RUN, and again during the DONE cycle → both ignored; result q=28, r=4. A start one cycle after done → accepted; result q=3, r=0.
- Start a=200, b=7, then assert rst asynchronously (between clock edges) at iteration 4 → all outputs 0 immediately, no done pulse. A fresh start after rst is released completes correctly.
- Randomised sweep of 1000 (a, b) pairs with b≠0 → q = a/b and r = a%b at every done; done is never asserted twice for one start.
